// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the HI/LO multiply/divide sequencer.
// MULDIV_FAST_MUL_EN adds the MFAST state for the single-cycle multiply build.
package mips_pkg;

   localparam int XLEN = 32;

   // aluOP[1:0] for the HI/LO operations (aluOP 01100..01111)
   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
`ifdef MULDIV_FAST_MUL_EN
      MFAST = 2'd2,
`endif
      FIX   = 2'd3
   } md_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring shift-subtract for divide. acc holds {high half, low half}.
module muldiv_iter_core #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc_next
);

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN+1:0] div_diff;
   logic            div_unused;

   // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, operand};
      if (is_div) begin
         // no borrow: partial remainder >= divisor, so subtract and emit a 1
         if (!div_diff[XLEN+1])
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         acc_next = {mul_sum, acc[XLEN-1:1]};
      end
   end

   // the difference always fits XLEN bits when it is kept
   assign div_unused = div_diff[XLEN];

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: iterative multiply and restoring divide,
// pipeline stall and MTHI/MTLO. Define MULDIV_FAST_MUL_EN for a single-cycle multiply.
module muldiv_seq
   import mips_pkg::*;
#(
   parameter int XLEN   = mips_pkg::XLEN,
   parameter int ITER_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   input  logic            mt_hi,
   input  logic            mt_lo,
   input  logic [XLEN-1:0] mt_data,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(XLEN - 1);

   md_state_e         state, state_next;
   logic [ITER_W-1:0] count;
   logic [2*XLEN-1:0] acc, acc_next;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              is_div, neg_res, neg_rem;

   logic              accept, signed_op, div_op, a_neg, b_neg;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_hi, fix_lo;

   always_comb begin
      accept    = (state == IDLE) && start && !flush;
      signed_op = (op == MD_MULT) || (op == MD_DIV);
      div_op    = (op == MD_DIV) || (op == MD_DIVU);
      a_neg     = signed_op && src_a[XLEN-1];
      b_neg     = signed_op && src_b[XLEN-1];
      abs_a     = a_neg ? -src_a : src_a;
      abs_b     = b_neg ? -src_b : src_b;
   end

   // Sign correction and result mapping; divide by zero forces an all-ones quotient.
   always_comb begin
      prod_fix = neg_res ? -acc : acc;
      quot_fix = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (is_div) begin
         fix_hi = rem_fix;
         fix_lo = (mag_b == '0) ? '1 : quot_fix;
      end else begin
         fix_hi = prod_fix[2*XLEN-1:XLEN];
         fix_lo = prod_fix[XLEN-1:0];
      end
   end

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .is_div   (is_div),
      .acc      (acc),
      .operand  (is_div ? mag_b : mag_a),
      .acc_next (acc_next)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
               state_next = div_op ? RUN : MFAST;
`else
               state_next = RUN;
`endif
            end
         end
         RUN: begin
            if (flush)                   state_next = IDLE;
            else if (count == LAST_ITER) state_next = FIX;
         end
`ifdef MULDIV_FAST_MUL_EN
         MFAST:   state_next = flush ? IDLE : FIX;
`endif
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the whole datapath is reset, so a mid-operation reset leaves no stale operands behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         acc     <= '0;
         mag_a   <= '0;
         mag_b   <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mag_a   <= abs_a;
                  mag_b   <= abs_b;
                  is_div  <= div_op;
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  count   <= '0;
                  // low half seeds the multiplier or the dividend
                  acc     <= {{XLEN{1'b0}}, div_op ? abs_a : abs_b};
               end else if (!start) begin
                  if (mt_hi) hi <= mt_data;
                  if (mt_lo) lo <= mt_data;
               end
            end
            RUN: begin
               if (!flush) begin
                  acc   <= acc_next;
                  count <= count + 1'b1;
               end
            end
`ifdef MULDIV_FAST_MUL_EN
            MFAST: begin
               if (!flush) acc <= fast_prod;
            end
`endif
            FIX: begin
               if (!flush) begin
                  hi   <= fix_hi;
                  lo   <= fix_lo;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign stall = start | busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed spec cases, randomized ops against
// an arithmetic reference model, MTHI/MTLO, flush, ignored start and async reset.
module tb_muldiv_seq;
   import mips_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int         MUL_LAT  = 3;
   localparam logic [1:0] FLUSH_OP = MD_DIVU;
`else
   localparam int         MUL_LAT  = 34;
   localparam logic [1:0] FLUSH_OP = MD_MULTU;
`endif
   localparam int DIV_LAT = 34;

   logic        clk, rst_n, start, flush, mt_hi, mt_lo, stall, busy, done;
   logic [1:0]  op;
   logic [31:0] src_a, src_b, mt_data, hi, lo;
   int          checks = 0;
   int          errors = 0;

   muldiv_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .flush   (flush),
      .mt_hi   (mt_hi),
      .mt_lo   (mt_lo),
      .mt_data (mt_data),
      .stall   (stall),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference result {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      int          sa, sb;
      logic [31:0] q, r;
      sa = a;
      sb = b;
      case (o)
         MD_MULT: begin
            p = longint'(sa) * longint'(sb);
            return p;
         end
         MD_MULTU: return {32'h0, a} * {32'h0, b};
         default: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            if (o == MD_DIVU) return {a % b, a / b};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mt_set(input logic [31:0] h, input logic [31:0] l);
      mt_hi = 1'b1; mt_data = h; tick(); mt_hi = 1'b0;
      mt_lo = 1'b1; mt_data = l; tick(); mt_lo = 1'b0;
   endtask

   // Drive start for one cycle; returns in cycle 1 of the operation.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; src_a = a; src_b = b; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc_in, output int cyc_out);
      int c;
      c = cyc_in;
      while (!done && c < 200) begin
         tick();
         c++;
      end
      cyc_out = c;
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] want, input int lat);
      int cyc, stall_cyc;
      op = o; src_a = a; src_b = b; start = 1'b1;
      #1;
      stall_cyc = int'(stall);
      tick();
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 200) begin
         stall_cyc += int'(stall);
         tick();
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'(lat));
      check({tag, " stall_cycles"}, 64'(stall_cyc), 64'(lat));
      check({tag, " stall_at_done"}, 64'(stall), 64'(0));
      check({tag, " busy_at_done"}, 64'(busy), 64'(0));
      check({tag, " hi"}, 64'(hi), 64'(want[63:32]));
      check({tag, " lo"}, 64'(lo), 64'(want[31:0]));
      tick();
      check({tag, " done_pulse"}, 64'(done), 64'(0));
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      int          cyc;
      bit          seen;

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
      op = 2'b00; src_a = '0; src_b = '0; mt_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset stall", 64'(stall), 64'(0));
      check("reset hi", 64'(hi), 64'(0));
      check("reset lo", 64'(lo), 64'(0));
      rst_n = 1'b1;
      tick();

      // directed cases with hand-derived results
      do_op("mult_neg2x3", MD_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, MUL_LAT);
      do_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT);
      do_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DIV_LAT);
      do_op("div_5_0", MD_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, DIV_LAT);
      do_op("div_m7_0", MD_DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, DIV_LAT);
      do_op("divu_big_0", MD_DIVU, 32'h80000000, 32'd0, 64'h80000000_FFFFFFFF, DIV_LAT);
      do_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DIV_LAT);
      do_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MUL_LAT);

      // randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       r_b = 32'h0;
            1:       r_b = $urandom_range(1, 15);
            2:       r_b = 32'hFFFFFFFF;
            default: r_b = $urandom;
         endcase
         do_op($sformatf("rand%0d", i), r_op, r_a, r_b, model(r_op, r_a, r_b),
               r_op[1] ? DIV_LAT : MUL_LAT);
      end

      // MTHI / MTLO in IDLE
      mt_set(32'h1234, 32'hABCD);
      check("mt hi", 64'(hi), 64'(32'h1234));
      check("mt lo", 64'(lo), 64'(32'hABCD));
      mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h5A5A5A5A;
      tick();
      mt_hi = 1'b0; mt_lo = 1'b0;
      check("mt both hi", 64'(hi), 64'(32'h5A5A5A5A));
      check("mt both lo", 64'(lo), 64'(32'h5A5A5A5A));

      // start+flush together: flush wins; MTHI with start high is ignored
      start = 1'b1; flush = 1'b1; mt_hi = 1'b1; mt_data = 32'hFFFF0000;
      tick();
      start = 1'b0; flush = 1'b0; mt_hi = 1'b0;
      check("start_flush busy", 64'(busy), 64'(0));
      check("mt_with_start hi", 64'(hi), 64'(32'h5A5A5A5A));

      // MT strobes while busy are ignored
      mt_set(32'h11111111, 32'h22222222);
      launch(MD_DIVU, 32'd1000, 32'd10);
      mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'hDEADBEEF;
      tick();
      mt_hi = 1'b0; mt_lo = 1'b0;
      check("mt_busy hi", 64'(hi), 64'(32'h11111111));
      check("mt_busy lo", 64'(lo), 64'(32'h22222222));
      wait_done(2, cyc);
      check("mt_busy latency", 64'(cyc), 64'(DIV_LAT));
      check("mt_busy result lo", 64'(lo), 64'(32'd100));
      check("mt_busy result hi", 64'(hi), 64'(0));
      tick();

      // second start during RUN is ignored
      launch(MD_DIV, 32'hFFFFFC18, 32'd7);
      repeat (4) tick();
      op = MD_MULTU; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(6, cyc);
      check("restart latency", 64'(cyc), 64'(DIV_LAT));
      check("restart hi", 64'(hi), 64'(model(MD_DIV, 32'hFFFFFC18, 32'd7) >> 32));
      check("restart lo", 64'(lo), 64'(model(MD_DIV, 32'hFFFFFC18, 32'd7) & 64'hFFFFFFFF));
      tick();

      // flush mid-RUN at cycle 10
      mt_set(32'h0BAD0BAD, 32'h600D600D);
      launch(FLUSH_OP, 32'h12345678, 32'h9ABCDEF0);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_run busy", 64'(busy), 64'(0));
      seen = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         tick();
      end
      check("flush_run no_done", 64'(seen), 64'(0));
      check("flush_run hi", 64'(hi), 64'(32'h0BAD0BAD));
      check("flush_run lo", 64'(lo), 64'(32'h600D600D));

      // flush in the FIX cycle (cycle 33)
      launch(MD_DIVU, 32'd77, 32'd5);
      repeat (32) tick();
      check("fix busy", 64'(busy), 64'(1));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_fix busy", 64'(busy), 64'(0));
      check("flush_fix done", 64'(done), 64'(0));
      check("flush_fix hi", 64'(hi), 64'(32'h0BAD0BAD));
      check("flush_fix lo", 64'(lo), 64'(32'h600D600D));

      // async reset mid-RUN
      mt_set(32'hCAFEF00D, 32'h12345678);
      launch(MD_DIVU, 32'hFFFFFFFF, 32'd3);
      repeat (14) tick();
      rst_n = 1'b0;
      #1;
      check("arst hi", 64'(hi), 64'(0));
      check("arst lo", 64'(lo), 64'(0));
      check("arst busy", 64'(busy), 64'(0));
      check("arst stall", 64'(stall), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      check("arst idle", 64'(busy), 64'(0));
      do_op("post_reset", MD_MULTU, 32'd7, 32'd6, 64'd42, MUL_LAT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource of the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-iteration shift-add multiplier or restoring divider.
- Stalls the pipeline while busy and owns the architectural HI/LO registers, including MTHI/MTLO writes.
- Sits beside the ALU; the decoder's aluOP codes 01100..01111 select the operation.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER_W, 6, iteration counter width; must hold XLEN+1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (aluOP[1:0]).
- src_a  in  XLEN  rs operand (multiplicand / dividend).
- src_b  in  XLEN  rt operand (multiplier / divisor).
- flush  in  1  exception/ERET flush; aborts any operation in flight.
- mt_hi  in  1  MTHI write strobe.
- mt_lo  in  1  MTLO write strobe.
- mt_data  in  XLEN  data for MTHI/MTLO.
- stall  out  1  combinational: start | (state != IDLE).
- busy  out  1  registered: state != IDLE.
- done  out  1  one-cycle pulse; HI/LO updated on the same edge.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, busy=0, done=0, hi=0, lo=0, internal accumulators=0.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE + start + !flush (edge 0):
  - latch |src_a| and |src_b| (raw values for unsigned ops);
  - latch result sign (a^b) and remainder sign (a);
  - clear count and accumulator; go to RUN.
- RUN (edges 1..32), one iteration per cycle:
  - multiply: 64-bit shift-add on the LSB of the multiplier;
  - divide: restoring shift-subtract, one quotient bit per cycle;
  - count increments each cycle; at count==31 go to FIX.
- FIX (edge 33): apply two's-complement sign correction, write hi/lo, done=1 for the following cycle, go to IDLE.
- Latency: done observed 34 cycles after the start cycle. The stall covers the start cycle through the FIX cycle and is low in the done cycle.
- Result mapping: MULT/MULTU → {hi,lo} = 64-bit product. DIV/DIVU → lo = quotient, hi = remainder; remainder takes the dividend's sign.
- Divide by zero (src_b==0), fixed latency unchanged:
  - lo = 32'hFFFFFFFF, hi = src_a (raw), for both DIV and DIVU;
  - no exception is raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Flush in RUN or FIX: return to IDLE on the next edge; no done; hi/lo unchanged.
- start while busy: ignored.
- start and flush in the same cycle: flush wins, stays IDLE.
- mt_hi/mt_lo: take effect in IDLE only, when start=0; ignored otherwise (the pipeline stall prevents the conflict). If mt_hi and mt_lo are both high, both registers are written.
- Reset mid-operation: immediate return to IDLE; all outputs go to their reset values.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU skip RUN.
  - Single-cycle 64-bit product computed from the latched operands in state MFAST, then FIX.
  - done arrives 3 cycles after start.
  - Divide is unchanged.
- Undefined: MFAST state does not exist; multiply uses the 32-cycle iterative path.

Decomposition:
- Shared package mips_pkg:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state enum (IDLE, RUN, MFAST, FIX);
  - XLEN constant.
- One natural sub-module, muldiv_iter_core: the per-iteration datapath (add/subtract and shift), combinational, instantiated once.
- Sequencing, sign fix and HI/LO stay in muldiv_seq.

Test Plan:
- MULT 0xFFFFFFFE(-2) × 0x00000003 → done at start+34; hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall high for 34 cycles.
- DIVU 100 / 7 → lo=14, hi=2. DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5 / 0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- Start MULTU, assert flush at cycle 10 → busy low next cycle, no done, hi/lo keep their prior values. A second start during RUN is ignored.
- MTHI 0x1234 then MTLO 0xABCD in IDLE → hi=0x1234, lo=0xABCD. Async reset mid-RUN → hi=lo=0, busy=0 immediately.
- With MULDIV_FAST_MUL_EN: MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done at start+3.
